pe_traffic_sink: RTL

PE_TRAFFIC_SINK -- requirements
Module: pe_traffic_sink

---
 rtl/pe_traffic_sink.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pe_traffic_sink.sv
// NoC traffic sink for one processing element. Accepts flits, checks the
// destination address and per-source sequence numbers, and accumulates
// latency statistics. Optional back-pressure inserts a fixed number of
// ready-low cycles after every accepted flit until the expected packet
// count has been reached.
module pe_traffic_sink #(
  parameter logic [3:0]  ADDRESS       = 4'd0,
  parameter int unsigned EXPECTED_PKTS = 100,
  parameter int unsigned STALL_CYCLES  = 0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_data,
  input  logic        i_data_valid,
  output logic        o_data_ready,
  output logic [31:0] o_rx_count,
  output logic [15:0] o_misroute_count,
  output logic [15:0] o_seq_err_count,
  output logic [31:0] o_lat_sum,
  output logic [15:0] o_lat_max,
  output logic        o_done
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [31:0] EXP_PKTS_W = 32'(EXPECTED_PKTS);
  localparam bit          STALL_EN   = (STALL_CYCLES != 0);
  localparam logic [15:0] STALL_LOAD = STALL_EN ? 16'(STALL_CYCLES - 1) : 16'd0;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [15:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {17'd0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  state_t      state, state_nxt;
  logic [15:0] stall_cnt, stall_cnt_nxt;
  logic [15:0] cyc_cnt;

  logic        acc_p0;
  logic        vld_p0, vld_p1;
  logic [15:0] hdr_p0, hdr_p1;
  logic [15:0] lat_p0, lat_p1;

  logic [7:0]  seq_tbl [16];
  logic [3:0]  dst_p1, src_p1;
  logic [7:0]  seq_p1;
  logic        done_hit;

  assign acc_p0   = i_data_valid & o_data_ready;
  assign dst_p1   = hdr_p1[15:12];
  assign src_p1   = hdr_p1[11:8];
  assign seq_p1   = hdr_p1[7:0];
  assign done_hit = vld_p1 && ((o_rx_count + 32'd1) == EXP_PKTS_W);

  // State and stall counter registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= RUN;
      stall_cnt <= 16'd0;
    end else begin
      state     <= state_nxt;
      stall_cnt <= stall_cnt_nxt;
    end
  end

  // Next state, stall countdown and handshake outputs; DONE overrides any stall
  always_comb begin
    state_nxt     = state;
    stall_cnt_nxt = stall_cnt;
    o_data_ready  = 1'b1;
    o_done        = 1'b0;
    case (state)
      RUN: begin
        if (done_hit) begin
          state_nxt = DONE;
        end else if (i_data_valid && STALL_EN) begin
          state_nxt     = STALL;
          stall_cnt_nxt = STALL_LOAD;
        end
      end
      STALL: begin
        o_data_ready = 1'b0;
        if (done_hit) begin
          state_nxt     = DONE;
          stall_cnt_nxt = 16'd0;
        end else if (stall_cnt == 16'd0) begin
          state_nxt = RUN;
        end else begin
          stall_cnt_nxt = stall_cnt - 16'd1;
        end
      end
      DONE: begin
        o_done = 1'b1;
      end
      default: begin
        state_nxt     = RUN;
        stall_cnt_nxt = 16'd0;
      end
    endcase
  end

  // Free-running timebase used to stamp accepted flits
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) cyc_cnt <= 16'd0;
    else          cyc_cnt <= cyc_cnt + 16'd1;
  end

  // ---- stage 0: accepted flit header and its latency ----
  // Valid for the accept register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) vld_p0 <= 1'b0;
    else          vld_p0 <= acc_p0;
  end

  // Header capture and latency from the timebase at the accept edge
  always_ff @(posedge i_clk) begin
    if (acc_p0) begin
      hdr_p0 <= i_data[31:16];
      lat_p0 <= cyc_cnt - i_data[15:0];
    end
  end

  // ---- stage 1: registered flit and latency feeding the statistics ----
  // Valid for stage 1; reset drops any flit in flight
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) vld_p1 <= 1'b0;
    else          vld_p1 <= vld_p0;
  end

  // Stage 1 data register
  always_ff @(posedge i_clk) begin
    if (vld_p0) begin
      hdr_p1 <= hdr_p0;
      lat_p1 <= lat_p0;
    end
  end

  // ---- stage 2: statistics ----
  // The sequence table is read and written in this same stage, so a
  // following flit from the same source always sees the updated entry.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_rx_count       <= 32'd0;
      o_misroute_count <= 16'd0;
      o_seq_err_count  <= 16'd0;
      o_lat_sum        <= 32'd0;
      o_lat_max        <= 16'd0;
      for (int i = 0; i < 16; i++) seq_tbl[i] <= 8'd0;
    end else if (vld_p1) begin
      o_rx_count <= o_rx_count + 32'd1;
      if (dst_p1 != ADDRESS)         o_misroute_count <= sat_inc16(o_misroute_count);
      if (seq_p1 != seq_tbl[src_p1]) o_seq_err_count  <= sat_inc16(o_seq_err_count);
      seq_tbl[src_p1] <= seq_p1 + 8'd1;
      o_lat_sum <= sat_add32(o_lat_sum, lat_p1);
      if (lat_p1 > o_lat_max) o_lat_max <= lat_p1;
    end
  end

endmodule
